serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial two's-complement subtractor computing DIFF = A − B one bit per clock, LSB first, with a single borrow flip-flop. It is the subtracting counterpart of the combinational full-adder datapath. It sits in the arithmetic group as a low-area alternative to a parallel ripple subtractor, and it exposes both a serial result stream and a parallel result.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH ≥ 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  request to begin; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on an accepted start.
- b  input  WIDTH  subtrahend; captured on an accepted start.
- busy  output  1  high in RUN and DONE.
- diff_bit  output  1  serial difference bit of the current RUN cycle.
- diff_bit_valid  output  1  high for each RUN cycle (exactly WIDTH cycles per operation).
- diff  output  WIDTH  parallel difference; valid while done=1 and held until the next accepted start.
- borrow_out  output  1  final borrow; 1 ⇔ unsigned a < b.
- overflow  output  1  signed overflow of a − b.
- done  output  1  one-cycle pulse marking the result as valid.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 captures a and b into shift registers, clears the borrow flop and bit counter, and moves to RUN.
  - start=0 stays in IDLE.
- RUN, each cycle, with a0/b0 as the LSBs of the shift registers and bin as the borrow flop:
  - diff_bit = a0 ^ b0 ^ bin.
  - bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
  - On the clock edge:
    - the borrow flop takes bout;
    - the a and b registers shift right;
    - the diff register shifts right with diff_bit inserted at the MSB;
    - the counter increments.
  - When the counter reaches WIDTH−1 on this edge, the state moves to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - borrow_out = final borrow flop.
  - overflow = (a_msb ≠ b_msb) & (diff[WIDTH−1] ≠ a_msb), using the captured operand MSB.
  - The next state is IDLE unconditionally.
- start is ignored while busy=1; no queueing and no error flag.
- diff, borrow_out and overflow hold their values through IDLE until the next accepted start.
- Arithmetic is modulo 2^WIDTH. Wrap-around is expected and is reported only through borrow_out and overflow.
- Reset value of every output:
  - busy, diff_bit, diff_bit_valid, done = 0.
  - diff = 0.
  - borrow_out = 0, overflow = 0.
  - State = IDLE.
- Reset mid-operation aborts immediately. No done pulse is produced and the partial result is discarded (diff returns to 0).

## Timing
- start is sampled at edge E0 while in IDLE.
- RUN occupies the WIDTH cycles following E0. Bit i appears on diff_bit in the (i+1)-th cycle after E0, with diff_bit_valid=1.
- DONE is the cycle after the last RUN cycle. done=1 there, WIDTH+1 cycles after E0.
- The earliest next start is accepted at the edge that ends DONE+1, i.e. one IDLE cycle is mandatory between operations.
- Throughput is one operation per WIDTH+2 cycles.
- WIDTH=1: one RUN cycle, then DONE.
- diff_bit and diff_bit_valid are combinational from registered state only; there is no input-to-output combinational path.

## Structure
- Shared package serial_arith_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a function returning the counter width, $clog2(WIDTH) with a minimum of 1.
- Sub-module full_subtractor (combinational):
  - inputs x, y, bin; outputs d, bout;
  - instantiated once for the per-bit logic;
  - reusable by a future parallel ripple subtractor.
- Top level contains the FSM, the operand and diff shift registers, the borrow flop, the counter and the result flags.

## Test plan
- WIDTH=8, a=5, b=3, start 1 cycle -> diff_bit sequence LSB-first 0,1,0,0,0,0,0,0; done at cycle 9; diff=0x02, borrow_out=0, overflow=0.
- a=3, b=5 -> diff=0xFE, borrow_out=1, overflow=0.
- a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1.
- a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, overflow=1.
- Start a=9, b=4; reassert start with a=1, b=1 during RUN -> second start ignored; diff=0x05 and exactly one done.
- Assert rst at RUN cycle 4 -> all outputs 0 immediately, no done; a following start with a=0, b=0 gives diff=0x00, borrow_out=0, overflow=0, done at cycle 9.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared state encoding and sizing helpers for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit difference and borrow, x - y - bin.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b with one borrow flop,
// streaming each difference bit and presenting the parallel result on done.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             diff_bit,
    output logic             diff_bit_valid,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             done
);

    import serial_arith_pkg::*;

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_next;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             a_msb;
    logic             b_msb;
    logic             d;
    logic             bout;

    full_subtractor u_fs (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (borrow),
        .d    (d),
        .bout (bout)
    );

    if (WIDTH == 1) begin : g_narrow
        assign diff_next = d;
    end else begin : g_wide
        assign diff_next = {d, diff[WIDTH-1:1]};
    end

    assign diff_bit_valid = (state == RUN);
    assign diff_bit       = diff_bit_valid & d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            diff       <= '0;
            cnt        <= '0;
            borrow     <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state      <= RUN;
                    a_sr       <= a;
                    b_sr       <= b;
                    a_msb      <= a[WIDTH-1];
                    b_msb      <= b[WIDTH-1];
                    cnt        <= '0;
                    borrow     <= 1'b0;
                    busy       <= 1'b1;
                    borrow_out <= 1'b0;
                    overflow   <= 1'b0;
                end
                RUN: begin
                    borrow <= bout;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    diff   <= diff_next;
                    cnt    <= cnt + 1'b1;
                    // the bit shifted in on the last edge is the result MSB
                    if (cnt == CW'(WIDTH - 1)) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        borrow_out <= bout;
                        overflow   <= (a_msb != b_msb) & (d != a_msb);
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vector table plus ignored-start and mid-run reset sequences.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         diff_bit;
    logic         diff_bit_valid;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;
    logic         done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    vec_t vecs [9];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .a              (a),
        .b              (b),
        .busy           (busy),
        .diff_bit       (diff_bit),
        .diff_bit_valid (diff_bit_valid),
        .diff           (diff),
        .borrow_out     (borrow_out),
        .overflow       (overflow),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge while IDLE; returns at the negedge of the following IDLE cycle.
    task automatic run_op(input vec_t v);
        a = v.a;
        b = v.b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~v.a;
        b = ~v.b;
        for (int i = 0; i < W; i++) begin
            chk("bit_valid", diff_bit_valid, 1);
            chk("diff_bit", diff_bit, v.d[i]);
            chk("busy_run", busy, 1);
            chk("done_early", done, 0);
            @(negedge clk);
        end
        chk("done", done, 1);
        chk("busy_done", busy, 1);
        chk("valid_done", diff_bit_valid, 0);
        chk("diff", diff, v.d);
        chk("borrow_out", borrow_out, v.bo);
        chk("overflow", overflow, v.ov);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
        chk("diff_hold", diff, v.d);
        chk("borrow_hold", borrow_out, v.bo);
        chk("overflow_hold", overflow, v.ov);
    endtask

    initial begin
        int dones;
        logic [W-1:0] seen;
        vecs[0] = '{a: 8'h05, b: 8'h03, d: 8'h02, bo: 1'b0, ov: 1'b0};
        vecs[1] = '{a: 8'h03, b: 8'h05, d: 8'hFE, bo: 1'b1, ov: 1'b0};
        vecs[2] = '{a: 8'h80, b: 8'h01, d: 8'h7F, bo: 1'b0, ov: 1'b1};
        vecs[3] = '{a: 8'h7F, b: 8'hFF, d: 8'h80, bo: 1'b1, ov: 1'b1};
        vecs[4] = '{a: 8'h00, b: 8'h01, d: 8'hFF, bo: 1'b1, ov: 1'b0};
        vecs[5] = '{a: 8'hFF, b: 8'hFF, d: 8'h00, bo: 1'b0, ov: 1'b0};
        vecs[6] = '{a: 8'h7F, b: 8'h80, d: 8'hFF, bo: 1'b1, ov: 1'b1};
        vecs[7] = '{a: 8'h80, b: 8'h7F, d: 8'h01, bo: 1'b0, ov: 1'b1};
        vecs[8] = '{a: 8'hA5, b: 8'h5A, d: 8'h4B, bo: 1'b0, ov: 1'b1};
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_diff_bit", diff_bit, 0);
        chk("rst_valid", diff_bit_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow_out, 0);
        chk("rst_overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 9; k++) run_op(vecs[k]);
        // a second start during RUN must be ignored
        a = 8'h09;
        b = 8'h04;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'h01;
        b = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        seen = '0;
        for (int i = 0; i < 14; i++) begin
            if (done) begin
                dones++;
                seen = diff;
            end
            @(negedge clk);
        end
        chk("ignore_dones", dones, 1);
        chk("ignore_diff", seen, 8'h05);
        chk("ignore_borrow", borrow_out, 0);
        // reset during RUN cycle 4 aborts with no done
        a = 8'h05;
        b = 8'h03;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_diff", diff, 8'h40);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_diff_bit", diff_bit, 0);
        chk("abort_valid", diff_bit_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_diff", diff, 0);
        chk("abort_borrow", borrow_out, 0);
        chk("abort_overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("abort_no_done", dones, 0);
        run_op('{a: 8'h00, b: 8'h00, d: 8'h00, bo: 1'b0, ov: 1'b0});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
